// File: rtl/nway_cache_set_pkg.sv
// Shared types for the N-way cache set: FSM state encoding and a helper
// that derives the block width from the offset and word widths.
package nway_cache_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND
  } cache_state_e;

  function automatic int block_bits(input int offset_bits, input int word_size);
    return (2 ** offset_bits) * word_size;
  endfunction

endpackage

// File: rtl/nway_cache_set_if.sv
// Request/response and memory-side signals of one cache set.
//   slave  : the cache set (accepts requests, drives the memory port)
//   master : the environment (requester plus memory controller)
//   req_*  : byte request handshake; resp_* : one-cycle response strobe
//   mem_*  : block-wide writeback/refill transaction, completed by mem_ack
interface nway_cache_set_if
  import nway_cache_set_pkg::*;
#(
  parameter int TAG_SIZE    = 19,
  parameter int OFFSET_BITS = 3,
  parameter int WORD_SIZE   = 8
) ();

  localparam int BLOCK_BITS = block_bits(OFFSET_BITS, WORD_SIZE);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [TAG_SIZE-1:0]    req_tag;
  logic [OFFSET_BITS-1:0] req_offset;
  logic [WORD_SIZE-1:0]   req_wdata;

  logic                   resp_valid;
  logic [WORD_SIZE-1:0]   resp_rdata;
  logic                   resp_hit;

  logic                   mem_req;
  logic                   mem_we;
  logic [TAG_SIZE-1:0]    mem_tag;
  logic [BLOCK_BITS-1:0]  mem_wdata;
  logic                   mem_ack;
  logic [BLOCK_BITS-1:0]  mem_rdata;

  modport slave (
    input  req_valid, req_we, req_tag, req_offset, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_tag, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_tag, req_offset, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_tag, mem_wdata
  );

endinterface

// File: rtl/nway_cache_set_ages.sv
// True-LRU age vector for one cache set.
//   touch_i/touch_way_i : make a way MRU (age 0), ageing every younger way by one
//   valid_i             : per-way valid mask, used for victim choice
//   ages_o              : age of way i at [AGE_W*i +: AGE_W]; 0 = MRU
//   victim_way_o        : lowest-index invalid way, else the oldest way
module cache_lru_ages #(
  parameter int WAYS = 4
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          touch_i,
  input  logic [$clog2(WAYS)-1:0]       touch_way_i,
  input  logic [WAYS-1:0]               valid_i,
  output logic [WAYS*$clog2(WAYS)-1:0]  ages_o,
  output logic [$clog2(WAYS)-1:0]       victim_way_o
);

  localparam int AGE_W = $clog2(WAYS);

  logic [AGE_W-1:0] age_q [WAYS];

  // Only ways younger than the touched one move, so the ages stay a
  // permutation of 0..WAYS-1 and never wrap.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < WAYS; k++) age_q[k] <= AGE_W'(k);
    end else if (touch_i) begin
      for (int k = 0; k < WAYS; k++) begin
        if (AGE_W'(k) == touch_way_i)            age_q[k] <= '0;
        else if (age_q[k] < age_q[touch_way_i])  age_q[k] <= age_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    ages_o = '0;
    for (int k = 0; k < WAYS; k++) ages_o[AGE_W*k +: AGE_W] = age_q[k];
  end

  always_comb begin
    logic found;
    found        = 1'b0;
    victim_way_o = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (!found && !valid_i[k]) begin
        victim_way_o = AGE_W'(k);
        found        = 1'b1;
      end
    end
    if (!found) begin
      for (int k = 0; k < WAYS; k++) begin
        if (age_q[k] == AGE_W'(WAYS-1)) victim_way_o = AGE_W'(k);
      end
    end
  end

endmodule

// File: rtl/nway_cache_set.sv
// One set of an N-way set-associative, write-back, write-allocate cache
// with true-LRU replacement. Serves one byte request at a time; misses
// run writeback (if the victim is dirty) then refill on the block port.
//   clk, rst_b : clock, asynchronous active-low reset
//   bus        : request/response and memory port (slave side)
//   ages_o     : per-way LRU age, way i at [AGE_W*i +: AGE_W]
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | ready for a request; fields captured on handshake
// LOOKUP    | tag compare; hit served here, miss picks the victim
// WRITEBACK | dirty victim block written to memory until mem_ack
// REFILL    | requested block fetched; installed on the mem_ack edge
// RESPOND   | one-cycle resp_valid strobe
module nway_cache_set
  import nway_cache_set_pkg::*;
#(
  parameter int WAYS        = 4,
  parameter int TAG_SIZE    = 19,
  parameter int OFFSET_BITS = 3,
  parameter int WORD_SIZE   = 8
) (
  input  logic                          clk,
  input  logic                          rst_b,
  nway_cache_set_if.slave               bus,
  output logic [WAYS*$clog2(WAYS)-1:0]  ages_o
);

  localparam int AGE_W      = $clog2(WAYS);
  localparam int BLOCK_BITS = block_bits(OFFSET_BITS, WORD_SIZE);
  localparam int SEL_W      = $clog2(BLOCK_BITS);

  cache_state_e state_q, state_d;

  logic                   req_we_q;
  logic [TAG_SIZE-1:0]    req_tag_q;
  logic [OFFSET_BITS-1:0] req_off_q;
  logic [WORD_SIZE-1:0]   req_wdata_q;
  logic [AGE_W-1:0]       victim_q;
  logic [WORD_SIZE-1:0]   resp_rdata_q;
  logic                   resp_hit_q;

  logic [TAG_SIZE-1:0]    tag_q  [WAYS];
  logic [BLOCK_BITS-1:0]  data_q [WAYS];
  logic [WAYS-1:0]        valid_q;
  logic [WAYS-1:0]        dirty_q;

  logic [WAYS-1:0]        hit_vec;
  logic                   hit;
  logic [AGE_W-1:0]       hit_way;
  logic [AGE_W-1:0]       victim_way;
  logic                   touch;
  logic [AGE_W-1:0]       touch_way;
  logic [SEL_W-1:0]       word_lsb;
  logic [BLOCK_BITS-1:0]  refill_blk;
  logic                   lookup_hit;
  logic                   refill_done;

  assign word_lsb    = SEL_W'(int'(req_off_q) * WORD_SIZE);
  assign lookup_hit  = (state_q == ST_LOOKUP) && hit;
  assign refill_done = (state_q == ST_REFILL) && bus.mem_ack;

  // At most one valid way can hold a given tag, so a plain OR-encode is enough.
  always_comb begin
    hit_way = '0;
    for (int k = 0; k < WAYS; k++) begin
      hit_vec[k] = valid_q[k] && (tag_q[k] == req_tag_q);
      if (hit_vec[k]) hit_way = AGE_W'(k);
    end
    hit = |hit_vec;
  end

  // A write miss installs the fetched block with the new byte already merged.
  always_comb begin
    refill_blk = bus.mem_rdata;
    if (req_we_q) refill_blk[word_lsb +: WORD_SIZE] = req_wdata_q;
  end

  assign touch     = lookup_hit || refill_done;
  assign touch_way = (state_q == ST_LOOKUP) ? hit_way : victim_q;

  cache_lru_ages #(.WAYS(WAYS)) u_ages (
    .clk          (clk),
    .rst_b        (rst_b),
    .touch_i      (touch),
    .touch_way_i  (touch_way),
    .valid_i      (valid_q),
    .ages_o       (ages_o),
    .victim_way_o (victim_way)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_tag    = '0;
    bus.mem_wdata  = '0;
    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit)                                             state_d = ST_RESPOND;
        else if (valid_q[victim_way] && dirty_q[victim_way]) state_d = ST_WRITEBACK;
        else                                                 state_d = ST_REFILL;
      end
      ST_WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_tag   = tag_q[victim_q];
        bus.mem_wdata = data_q[victim_q];
        if (bus.mem_ack) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        bus.mem_req = 1'b1;
        bus.mem_tag = req_tag_q;
        if (bus.mem_ack) state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        bus.resp_valid = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      req_we_q    <= 1'b0;
      req_tag_q   <= '0;
      req_off_q   <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.req_valid) begin
        req_we_q    <= bus.req_we;
        req_tag_q   <= bus.req_tag;
        req_off_q   <= bus.req_offset;
        req_wdata_q <= bus.req_wdata;
      end
      if (state_q == ST_LOOKUP && !hit) victim_q <= victim_way;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (lookup_hit && req_we_q) begin
      dirty_q[hit_way] <= 1'b1;
    end else if (refill_done) begin
      valid_q[victim_q] <= 1'b1;
      dirty_q[victim_q] <= req_we_q;
    end
  end

  // Tag and data storage carry no reset; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (lookup_hit && req_we_q) begin
      data_q[hit_way][word_lsb +: WORD_SIZE] <= req_wdata_q;
    end else if (refill_done) begin
      data_q[victim_q] <= refill_blk;
      tag_q[victim_q]  <= req_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
    end else if (lookup_hit) begin
      resp_rdata_q <= req_we_q ? req_wdata_q : data_q[hit_way][word_lsb +: WORD_SIZE];
      resp_hit_q   <= 1'b1;
    end else if (refill_done) begin
      resp_rdata_q <= refill_blk[word_lsb +: WORD_SIZE];
      resp_hit_q   <= 1'b0;
    end
  end

  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_hit   = resp_hit_q;

endmodule

// File: tb/tb_nway_cache_set.sv
// Bench for nway_cache_set: directed scenarios followed by random traffic,
// checked against a recency-list model of the set.
module tb_nway_cache_set;

  localparam int WAYS        = 4;
  localparam int TAG_SIZE    = 19;
  localparam int OFFSET_BITS = 3;
  localparam int WORD_SIZE   = 8;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [7:0] ages;
  int         total = 0;
  int         bad = 0;

  nway_cache_set_if #(.TAG_SIZE(TAG_SIZE), .OFFSET_BITS(OFFSET_BITS), .WORD_SIZE(WORD_SIZE)) bus ();

  nway_cache_set #(.WAYS(WAYS), .TAG_SIZE(TAG_SIZE), .OFFSET_BITS(OFFSET_BITS), .WORD_SIZE(WORD_SIZE)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .bus    (bus),
    .ages_o (ages)
  );

  always #5 clk = ~clk;

  // Model: per-way contents plus a recency list (front = most recently used).
  bit          m_valid [WAYS];
  bit          m_dirty [WAYS];
  logic [18:0] m_tag   [WAYS];
  logic [63:0] m_data  [WAYS];
  int          lru [$];

  task automatic model_reset();
    lru = {};
    for (int i = 0; i < WAYS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      lru.push_back(i);
    end
  endtask

  task automatic model_touch(input int w);
    int idx;
    idx = -1;
    for (int i = 0; i < lru.size(); i++) if (lru[i] == w) idx = i;
    if (idx >= 0) lru.delete(idx);
    lru.push_front(w);
  endtask

  function automatic logic [7:0] model_ages();
    logic [7:0] r;
    r = '0;
    for (int p = 0; p < lru.size(); p++) r[lru[p]*2 +: 2] = 2'(p);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request. The memory side acks after 'dly' wait cycles of each
  // transaction; refill returns 'fill'.
  task automatic do_req(input bit we, input logic [18:0] tag, input logic [2:0] off,
                        input logic [7:0] wd, input int dly, input logic [63:0] fill,
                        output logic [7:0] rdata_o, output logic hit_o,
                        output bit wb_o, output logic [63:0] wbdata_o);
    bit          hit, wb, done;
    int          w, v, ntr, nack, wcnt, cyc, nmem;
    logic [63:0] vblk;
    logic [18:0] vtag;
    logic [7:0]  exp_rd;
    hit = 1'b0;
    w   = 0;
    for (int i = 0; i < WAYS; i++) if (m_valid[i] && m_tag[i] == tag) begin hit = 1'b1; w = i; end
    v = -1;
    for (int i = 0; i < WAYS; i++) if (!m_valid[i] && v < 0) v = i;
    if (v < 0) v = lru[lru.size()-1];
    wb     = !hit && m_valid[v] && m_dirty[v];
    vblk   = m_data[v];
    vtag   = m_tag[v];
    exp_rd = we ? wd : (hit ? m_data[w][off*8 +: 8] : fill[off*8 +: 8]);
    ntr    = hit ? 0 : (wb ? 2 : 1);

    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_tag    = tag;
    bus.req_offset = off;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    cyc = 0; nack = 0; wcnt = 0; nmem = 0; done = 1'b0;
    wb_o = 1'b0; wbdata_o = '0; rdata_o = '0; hit_o = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        nmem++;
        if (wb && nack == 0) begin
          check("wb_mem_we", bus.mem_we, 1);
          check("wb_mem_tag", bus.mem_tag, vtag);
          check("wb_mem_wdata", bus.mem_wdata, vblk);
          wb_o     = 1'b1;
          wbdata_o = bus.mem_wdata;
        end else begin
          check("rf_mem_we", bus.mem_we, 0);
          check("rf_mem_tag", bus.mem_tag, tag);
        end
        if (wcnt == dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = (wb && nack == 0) ? {$urandom, $urandom} : fill;
          nack++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (bus.resp_valid) begin
        done    = 1'b1;
        rdata_o = bus.resp_rdata;
        hit_o   = bus.resp_hit;
        check("resp_rdata", bus.resp_rdata, exp_rd);
        check("resp_hit", bus.resp_hit, hit);
        check("resp_latency", cyc, 2 + ntr*(dly+1));
        check("mem_acks", nack, ntr);
        check("mem_req_cycles", nmem, ntr*(dly+1));
      end
    end
    check("resp_seen", done, 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("resp_single", bus.resp_valid, 0);
    check("ready_after", bus.req_ready, 1);

    if (hit) begin
      if (we) begin
        m_data[w][off*8 +: 8] = wd;
        m_dirty[w] = 1'b1;
      end
      model_touch(w);
    end else begin
      m_data[v] = fill;
      if (we) m_data[v][off*8 +: 8] = wd;
      m_tag[v]   = tag;
      m_valid[v] = 1'b1;
      m_dirty[v] = we;
      model_touch(v);
    end
    check("ages", ages, model_ages());
  endtask

  initial begin
    logic [7:0]  rd;
    logic        h;
    bit          wbf;
    logic [63:0] wbd;
    bit          seen;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_tag = '0; bus.req_offset = '0;
    bus.req_wdata = '0;   bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_hit", bus.resp_hit, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_tag", bus.mem_tag, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_ages", ages, 8'hE4);
    rst_b = 1'b1;

    // Cold read miss, then the same read hits
    do_req(1'b0, 19'h00011, 3'd2, 8'h00, 1, 64'h0706050403020100, rd, h, wbf, wbd);
    check("t1_rdata", rd, 8'h02);
    check("t1_hit", h, 0);
    check("t1_ages", ages, 8'hE4);
    do_req(1'b0, 19'h00011, 3'd2, 8'h00, 0, 64'h0, rd, h, wbf, wbd);
    check("t2_rdata", rd, 8'h02);
    check("t2_hit", h, 1);

    // Write hit, read back, then evict the dirty line
    do_req(1'b1, 19'h00011, 3'd5, 8'hAB, 0, 64'h0, rd, h, wbf, wbd);
    check("t3_write_hit", h, 1);
    do_req(1'b0, 19'h00011, 3'd5, 8'h00, 0, 64'h0, rd, h, wbf, wbd);
    check("t3_read_back", rd, 8'hAB);
    do_req(1'b0, 19'h00021, 3'd0, 8'h00, 0, {$urandom, $urandom}, rd, h, wbf, wbd);
    do_req(1'b0, 19'h00031, 3'd1, 8'h00, 1, {$urandom, $urandom}, rd, h, wbf, wbd);
    do_req(1'b0, 19'h00041, 3'd2, 8'h00, 2, {$urandom, $urandom}, rd, h, wbf, wbd);
    do_req(1'b0, 19'h00051, 3'd3, 8'h00, 1, {$urandom, $urandom}, rd, h, wbf, wbd);
    check("t3_wb_seen", wbf, 1);
    check("t3_wb_data", wbd, 64'h0706AB0403020100);

    // Clean LRU victim: fill A..D, touch A, miss E
    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    model_reset();
    do_req(1'b0, 19'h0000A, 3'd0, 8'h00, 0, {$urandom, $urandom}, rd, h, wbf, wbd);
    do_req(1'b0, 19'h0000B, 3'd0, 8'h00, 0, {$urandom, $urandom}, rd, h, wbf, wbd);
    do_req(1'b0, 19'h0000C, 3'd0, 8'h00, 0, {$urandom, $urandom}, rd, h, wbf, wbd);
    do_req(1'b0, 19'h0000D, 3'd0, 8'h00, 0, {$urandom, $urandom}, rd, h, wbf, wbd);
    do_req(1'b0, 19'h0000A, 3'd4, 8'h00, 0, 64'h0, rd, h, wbf, wbd);
    do_req(1'b0, 19'h0000E, 3'd6, 8'h00, 0, {$urandom, $urandom}, rd, h, wbf, wbd);
    check("t4_miss", h, 0);
    check("t4_no_wb", wbf, 0);
    check("t4_ages", ages, 8'hB1);

    // Stray ack while idle must not disturb anything
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check("stray_mem_req", bus.mem_req, 0);
      check("stray_ready", bus.req_ready, 1);
      check("stray_resp", bus.resp_valid, 0);
      check("stray_ages", ages, model_ages());
    end
    do_req(1'b0, 19'h0000A, 3'd4, 8'h00, 0, 64'h0, rd, h, wbf, wbd);
    check("stray_then_hit", h, 1);

    // Immediate ack and a 5-cycle ack delay
    do_req(1'b0, 19'h00123, 3'd1, 8'h00, 0, {$urandom, $urandom}, rd, h, wbf, wbd);
    do_req(1'b1, 19'h00124, 3'd7, 8'h5A, 5, {$urandom, $urandom}, rd, h, wbf, wbd);
    check("dly5_rdata", rd, 8'h5A);

    // Reset while waiting for refill data
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_tag = 19'h00099; bus.req_offset = 3'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen = 1'b1;
    end
    check("t5_refill_started", seen, 1);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("t5_mem_req_async", bus.mem_req, 0);
    check("t5_no_resp", bus.resp_valid, 0);
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    check("t5_resp_lost", seen, 0);
    check("t5_ready", bus.req_ready, 1);
    do_req(1'b0, 19'h0000A, 3'd4, 8'h00, 1, {$urandom, $urandom}, rd, h, wbf, wbd);
    check("t5_prior_tag_miss", h, 0);

    // Random traffic over a small tag pool to force hits, evictions and writebacks
    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), 19'(19'h00100 + $urandom_range(0, 5)),
             3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3),
             {$urandom, $urandom}, rd, h, wbf, wbd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
